// File: rtl/reg_seq_pkg.sv
// ============================================================================
// Module      : reg_seq_pkg
// Description : Shared types and constants for the register-file sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_seq_pkg;

  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_ADDR_W = 5;
  localparam int SEQ_DEPTH  = 1 << SEQ_ADDR_W;

  localparam logic OP_DUMP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DUMP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/reg_seq_out_slot.sv
// ============================================================================
// Module      : reg_seq_out_slot
// Description : One-entry valid/ready holding register for dump beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_seq_out_slot
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              free_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;

  // A new beat may be loaded in the same cycle the current one is taken.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sequencer.sv
// ============================================================================
// Module      : reg_file_sequencer
// Description : Bulk load/dump initiator for the 32x32 CPU register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DEPTH  = SEQ_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_Op,
  input  logic [ADDR_W-1:0] Cmd_Start,
  input  logic [ADDR_W:0]   Cmd_Count,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Load_Valid,
  output logic              Load_Ready,
  output logic [DATA_W-1:0] Dump_Data,
  output logic [ADDR_W-1:0] Dump_Addr,
  output logic              Dump_Valid,
  input  logic              Dump_Ready,
  output logic [ADDR_W-1:0] R_Addr_A,
  input  logic [DATA_W-1:0] R_Data_A,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] REM_LAST  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W:0]   count_clamped;
  logic              capture;
  logic              slot_free;

  assign count_clamped = (Cmd_Count > MAX_COUNT) ? MAX_COUNT : Cmd_Count;

  assign Cmd_Ready  = (state_q == ST_IDLE);
  assign Load_Ready = (state_q == ST_LOAD);
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_FIN);
  assign W_Addr     = waddr_q;
  assign W_Data     = wdata_q;
  assign Write_Reg  = wr_q;

  // The file reads combinationally, so the live address is presented in DUMP;
  // elsewhere the last presented address is simply held.
  assign R_Addr_A = (state_q == ST_DUMP) ? addr_q : raddr_q;
  assign raddr_d  = R_Addr_A;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          addr_d = Cmd_Start;
          rem_d  = count_clamped;
          if (count_clamped == '0) begin
            state_d = ST_FIN;
          end else begin
            case (Cmd_Op)
              OP_LOAD: state_d = ST_LOAD;
              OP_DUMP: state_d = ST_DUMP;
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end

      ST_LOAD: begin
        if (Load_Valid) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = Load_Data;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - REM_LAST;
          if (rem_q == REM_LAST) state_d = ST_FIN;
        end
      end

      ST_DUMP: begin
        if (slot_free) begin
          capture = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - REM_LAST;
          if (rem_q == REM_LAST) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (Dump_Valid && Dump_Ready) state_d = ST_FIN;
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
    end
  end

  reg_seq_out_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_slot (
    .Clk     (Clk),
    .Reset   (Reset),
    .load_i  (capture),
    .data_i  (R_Data_A),
    .addr_i  (addr_q),
    .ready_i (Dump_Ready),
    .valid_o (Dump_Valid),
    .data_o  (Dump_Data),
    .addr_o  (Dump_Addr),
    .free_o  (slot_free)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
// ============================================================================
// Module      : tb_reg_file_sequencer
// Description : Scoreboard bench for reg_file_sequencer with a register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sequencer;
  import reg_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Cmd_Valid = 1'b0;
  logic          Cmd_Ready;
  logic          Cmd_Op = 1'b0;
  logic [AW-1:0] Cmd_Start = '0;
  logic [AW:0]   Cmd_Count = '0;
  logic [DW-1:0] Load_Data = '0;
  logic          Load_Valid = 1'b0;
  logic          Load_Ready;
  logic [DW-1:0] Dump_Data;
  logic [AW-1:0] Dump_Addr;
  logic          Dump_Valid;
  logic          Dump_Ready = 1'b0;
  logic [AW-1:0] R_Addr_A;
  logic [DW-1:0] R_Data_A;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;
  logic          Write_Reg;
  logic          Busy;
  logic          Done;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_beats[$];
  int    n_checks = 0;
  int    n_pass = 0;

  logic [DW-1:0] rf [DEPTH];

  always #5 Clk = ~Clk;

  assign R_Data_A = rf[R_Addr_A];
  always @(posedge Clk) if (Write_Reg) rf[W_Addr] <= W_Data;

  reg_file_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Op     (Cmd_Op),
    .Cmd_Start  (Cmd_Start),
    .Cmd_Count  (Cmd_Count),
    .Load_Data  (Load_Data),
    .Load_Valid (Load_Valid),
    .Load_Ready (Load_Ready),
    .Dump_Data  (Dump_Data),
    .Dump_Addr  (Dump_Addr),
    .Dump_Valid (Dump_Valid),
    .Dump_Ready (Dump_Ready),
    .R_Addr_A   (R_Addr_A),
    .R_Data_A   (R_Data_A),
    .W_Addr     (W_Addr),
    .W_Data     (W_Data),
    .Write_Reg  (Write_Reg),
    .Busy       (Busy),
    .Done       (Done)
  );

  function automatic logic [DW-1:0] pat(input int i, input int k);
    return DW'(k) * 32'h0100_0000 + DW'(i) * 32'h11 + 32'h5;
  endfunction

  function automatic bit vpat(input int m, input int c);
    return (m == 0) ? 1'b1 : ((c % 3) != 2);
  endfunction

  function automatic bit rpat(input int m, input int c);
    return (m == 0) ? 1'b1 : ((c % 3) == 0);
  endfunction

  task automatic preload(input int k);
    @(posedge Clk); #1;
    for (int i = 0; i < DEPTH; i++) rf[i] <= pat(i, k);
    #1;
  endtask

  task automatic push_dump(input logic [AW-1:0] start, input int n, input int k);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + AW'(i);
      exp_beats.push_back('{a, pat(int'(a), k)});
    end
  endtask

  // Issues one command and scoreboards every write and dump beat until Done.
  task automatic run_op(input logic op, input logic [AW-1:0] start, input logic [AW:0] count,
                        input int vmode, input int rmode, input logic [DW-1:0] base,
                        output int done_cyc, output int n_wr, output int n_hs,
                        output int n_beats, output int first_cyc);
    beat_t         wexp[$];
    beat_t         b;
    logic [AW-1:0] waddr_next;
    logic          stall_prev;
    logic [DW-1:0] dprev;
    logic [AW-1:0] aprev;
    bit            seen_done;
    done_cyc = -1; n_wr = 0; n_hs = 0; n_beats = 0; first_cyc = -1;
    waddr_next = start; stall_prev = 1'b0; seen_done = 1'b0;
    dprev = '0; aprev = '0;
    @(posedge Clk); #1;
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Start = start; Cmd_Count = count;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (c > 0) begin
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
      end
      Load_Valid = (op == OP_LOAD) && vpat(vmode, c);
      Load_Data  = base + DW'(n_hs);
      Dump_Ready = (op == OP_DUMP) && rpat(rmode, c);
      @(negedge Clk);
      if (c == 0) begin
        n_checks++;
        if (Cmd_Ready !== 1'b1) $display("FAIL cmd_ready_accept: got %b want 1", Cmd_Ready);
        else n_pass++;
      end
      if (Write_Reg === 1'b1) begin
        n_wr++;
        if (first_cyc < 0) first_cyc = c;
        n_checks++;
        if (wexp.size() == 0) begin
          $display("FAIL write_unexpected: cycle %0d addr %0d data %h", c, W_Addr, W_Data);
        end else begin
          b = wexp.pop_front();
          if (W_Addr !== b.addr || W_Data !== b.data)
            $display("FAIL write_beat: got addr %0d data %h want addr %0d data %h",
                     W_Addr, W_Data, b.addr, b.data);
          else n_pass++;
        end
      end
      if (Load_Valid && Load_Ready === 1'b1) begin
        wexp.push_back('{waddr_next, Load_Data});
        waddr_next = waddr_next + AW'(1);
        n_hs++;
      end
      if (stall_prev) begin
        n_checks++;
        if (Dump_Valid !== 1'b1 || Dump_Data !== dprev || Dump_Addr !== aprev)
          $display("FAIL dump_stall_hold: got v%b addr %0d data %h want v1 addr %0d data %h",
                   Dump_Valid, Dump_Addr, Dump_Data, aprev, dprev);
        else n_pass++;
      end
      if (Dump_Valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        if (Dump_Ready) begin
          n_beats++;
          n_checks++;
          if (exp_beats.size() == 0) begin
            $display("FAIL dump_unexpected: addr %0d data %h", Dump_Addr, Dump_Data);
          end else begin
            b = exp_beats.pop_front();
            if (Dump_Addr !== b.addr || Dump_Data !== b.data)
              $display("FAIL dump_beat: got addr %0d data %h want addr %0d data %h",
                       Dump_Addr, Dump_Data, b.addr, b.data);
            else n_pass++;
          end
        end
      end
      stall_prev = (Dump_Valid === 1'b1) && !Dump_Ready;
      dprev = Dump_Data;
      aprev = Dump_Addr;
      if (Done === 1'b1) begin
        done_cyc = c;
        seen_done = 1'b1;
      end
    end
    Cmd_Valid = 1'b0; Load_Valid = 1'b0; Dump_Ready = 1'b0;
    n_checks++;
    if (!seen_done) $display("FAIL done_timeout: no Done within 200 cycles");
    else n_pass++;
    n_checks++;
    if (wexp.size() != 0 || exp_beats.size() != 0)
      $display("FAIL scoreboard_drain: got %0d writes %0d beats left want 0 0",
               wexp.size(), exp_beats.size());
    else n_pass++;
    exp_beats.delete();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (Dump_Valid !== 1'b0 || Dump_Data !== '0 || Dump_Addr !== '0 || W_Addr !== '0 ||
        W_Data !== '0 || Write_Reg !== 1'b0 || R_Addr_A !== '0 || Done !== 1'b0 ||
        Busy !== 1'b0 || Load_Ready !== 1'b0 || Cmd_Ready !== 1'b1)
      $display("FAIL reset_values: got dv%b dd%h da%0d wa%0d wd%h wr%b ra%0d dn%b bz%b lr%b cr%b want zeros and cr1",
               Dump_Valid, Dump_Data, Dump_Addr, W_Addr, W_Data, Write_Reg, R_Addr_A,
               Done, Busy, Load_Ready, Cmd_Ready);
    else n_pass++;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || Cmd_Ready !== 1'b1)
      $display("FAIL idle_after_reset: got busy %b ready %b want 0 1", Busy, Cmd_Ready);
    else n_pass++;
  endtask

  task automatic test_load_full_then_dump();
    int dc, nw, nh, nb, fc;
    run_op(OP_LOAD, 5'd0, 6'd32, 0, 0, 32'h100, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 33 || nw !== 32 || fc !== 2)
      $display("FAIL load_full_timing: got done %0d writes %0d first %0d want 33 32 2", dc, nw, fc);
    else n_pass++;
    for (int i = 0; i < 32; i++) exp_beats.push_back('{AW'(i), 32'h100 + DW'(i)});
    run_op(OP_DUMP, 5'd0, 6'd32, 0, 0, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 34 || nb !== 32 || fc !== 2)
      $display("FAIL dump_full_timing: got done %0d beats %0d first %0d want 34 32 2", dc, nb, fc);
    else n_pass++;
  endtask

  task automatic test_dump_wrap();
    int dc, nw, nh, nb, fc;
    preload(1);
    push_dump(5'd30, 4, 1);
    run_op(OP_DUMP, 5'd30, 6'd4, 0, 0, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 6 || nb !== 4 || fc !== 2)
      $display("FAIL dump_wrap_timing: got done %0d beats %0d first %0d want 6 4 2", dc, nb, fc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int dc, nw, nh, nb, fc;
    preload(2);
    push_dump(5'd5, 8, 2);
    run_op(OP_DUMP, 5'd5, 6'd8, 0, 1, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (nb !== 8 || dc < 0)
      $display("FAIL backpressure_beats: got beats %0d done %0d want 8 and a Done", nb, dc);
    else n_pass++;
  endtask

  task automatic test_count_limits();
    int dc, nw, nh, nb, fc;
    run_op(OP_LOAD, 5'd9, 6'd0, 0, 0, 32'hDEAD_0000, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 1 || nw !== 0 || nh !== 0)
      $display("FAIL load_count0: got done %0d writes %0d hs %0d want 1 0 0", dc, nw, nh);
    else n_pass++;
    run_op(OP_DUMP, 5'd9, 6'd0, 0, 0, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 1 || nb !== 0 || fc !== -1)
      $display("FAIL dump_count0: got done %0d beats %0d first %0d want 1 0 -1", dc, nb, fc);
    else n_pass++;
    preload(3);
    push_dump(5'd7, 32, 3);
    run_op(OP_DUMP, 5'd7, 6'd40, 0, 0, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 34 || nb !== 32)
      $display("FAIL dump_count40_clamp: got done %0d beats %0d want 34 32", dc, nb);
    else n_pass++;
  endtask

  task automatic test_load_gapped();
    int dc, nw, nh, nb, fc;
    run_op(OP_LOAD, 5'd28, 6'd5, 1, 0, 32'hA000, dc, nw, nh, nb, fc);
    n_checks++;
    if (nw !== 5 || nh !== 5 || dc < 0)
      $display("FAIL load_gapped_count: got writes %0d hs %0d done %0d want 5 5 and a Done", nw, nh, dc);
    else n_pass++;
    for (int i = 0; i < 5; i++)
      exp_beats.push_back('{AW'(28 + i), 32'hA000 + DW'(i)});
    run_op(OP_DUMP, 5'd28, 6'd5, 0, 0, '0, dc, nw, nh, nb, fc);
    n_checks++;
    if (nb !== 5 || dc !== 7)
      $display("FAIL load_gapped_readback: got beats %0d done %0d want 5 7", nb, dc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    int  beats, dc, nw, nh, nb, fc;
    bit  saw_done;
    beats = 0; saw_done = 1'b0;
    preload(4);
    @(posedge Clk); #1;
    Cmd_Valid = 1'b1; Cmd_Op = OP_DUMP; Cmd_Start = 5'd0; Cmd_Count = 6'd8; Dump_Ready = 1'b1;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      if (c > 0) begin
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
      end
      @(negedge Clk);
      if (Dump_Valid === 1'b1 && Dump_Ready) beats++;
    end
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0; Dump_Ready = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (beats !== 3 || Dump_Valid !== 1'b1 || Busy !== 1'b1)
      $display("FAIL reset_mid_setup: got beats %0d valid %b busy %b want 3 1 1", beats, Dump_Valid, Busy);
    else n_pass++;
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if (Dump_Valid !== 1'b0 || Busy !== 1'b0 || Write_Reg !== 1'b0 || Done !== 1'b0 || Cmd_Ready !== 1'b1)
      $display("FAIL reset_mid_async: got valid %b busy %b wr %b done %b ready %b want 0 0 0 0 1",
               Dump_Valid, Busy, Write_Reg, Done, Cmd_Ready);
    else n_pass++;
    repeat (2) begin
      @(negedge Clk);
      if (Done === 1'b1) saw_done = 1'b1;
    end
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    if (Done === 1'b1 || Busy === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (saw_done) $display("FAIL reset_mid_no_done: got Done/Busy after reset want none");
    else n_pass++;
    run_op(OP_LOAD, 5'd3, 6'd1, 0, 0, 32'h77, dc, nw, nh, nb, fc);
    n_checks++;
    if (dc !== 2 || nw !== 1 || fc !== 2)
      $display("FAIL reset_mid_new_cmd: got done %0d writes %0d first %0d want 2 1 2", dc, nw, fc);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rf[i] = '0;
    test_reset();
    test_load_full_then_dump();
    test_dump_wrap();
    test_backpressure();
    test_count_limits();
    test_load_gapped();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Bulk-access initiator for the 32×32 CPU register file: drives the file's read-port-A and write ports to load a run of registers from a streaming source or dump a run to a streaming sink. It sits between the debug/boot path and the register file, and owns the file's ports while Busy is high; external logic muxes CPU access off Busy. Reads rely on the register file's combinational read (R_Data_A valid in the same cycle as R_Addr_A); writes take effect at the file's next Clk edge.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- DEPTH, 32, number of registers (2**ADDR_W)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; forces IDLE
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  high in IDLE
- Cmd_Op  in  1  0 = dump, 1 = load
- Cmd_Start  in  ADDR_W  first register address
- Cmd_Count  in  ADDR_W+1  registers to access; values above DEPTH are clamped to DEPTH
- Load_Data  in  DATA_W  word to write
- Load_Valid  in  1  load word offered
- Load_Ready  out  1  high in LOAD
- Dump_Data  out  DATA_W  word read
- Dump_Addr  out  ADDR_W  source address of Dump_Data
- Dump_Valid  out  1  dump beat offered
- Dump_Ready  in  1  sink accepts beat
- R_Addr_A  out  ADDR_W  read address to register file
- R_Data_A  in  DATA_W  read data from register file
- W_Addr  out  ADDR_W  registered write address
- W_Data  out  DATA_W  registered write data
- Write_Reg  out  1  registered write strobe
- Busy  out  1  state ≠ IDLE
- Done  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, LOAD, DUMP, DRAIN, FIN.
- **IDLE:**
  - Cmd_Ready=1. On Cmd_Valid, latch addr=Cmd_Start and rem=min(Cmd_Count, DEPTH).
  - If rem=0, go to FIN. Otherwise go to LOAD (Cmd_Op=1) or DUMP (Cmd_Op=0).
- **LOAD:**
  - Load_Ready=1.
  - Each Load_Valid&Load_Ready registers W_Addr=addr, W_Data=Load_Data, Write_Reg=1 for the next cycle, then addr++ and rem--.
  - Write_Reg=0 in any cycle without a preceding handshake.
  - After the handshake with rem=1, go to FIN.
- **DUMP:**
  - R_Addr_A=addr.
  - When the slot is free (!Dump_Valid | Dump_Ready), capture Dump_Data=R_Data_A and Dump_Addr=addr, set Dump_Valid=1, then addr++ and rem--.
  - After the capture with rem=1, go to DRAIN.
- **DRAIN:** hold the last beat; on Dump_Valid&Dump_Ready, clear Dump_Valid and go to FIN.
- **Output slot:** Dump_Valid, once set, holds until the handshake; Dump_Data and Dump_Addr stay stable while Dump_Valid&!Dump_Ready.
- **FIN:** Done=1 for one cycle, then IDLE.
- **Address arithmetic:** mod DEPTH; address 31 wraps to 0. Start=30, Count=4 accesses 30, 31, 0, 1.
- **R_Addr_A outside DUMP:** holds its last value; don't-care to the register file.
- **Reset mid-operation:**
  - Immediately IDLE.
  - Pending dump beat dropped; Dump_Valid=0.
  - Write_Reg=0; no Done.
  - Remaining accesses abandoned.
- **Reset values:**
  - 0: Dump_Valid, Dump_Data, Dump_Addr, W_Addr, W_Data, Write_Reg, R_Addr_A, Done, Busy, Load_Ready.
  - 1: Cmd_Ready (IDLE). Inputs are ignored while Reset is low.

## Timing
- Cycle 0 is the command-accept cycle.
- **Load, Load_Valid held high:**
  - Handshakes in cycles 1..N.
  - Write_Reg high in cycles 2..N+1.
  - Done in cycle N+1, coincident with the last Write_Reg.
- **Dump, Dump_Ready held high:**
  - Dump_Valid high in cycles 2..N+1, one word per cycle.
  - Done in cycle N+2; Busy falls in cycle N+3.
- **Count=0:** Done in cycle 1, no port activity.
- **Back-pressure:** Dump_Ready low stalls the capture. rem and addr advance only on capture, so no word is skipped or repeated.
- Next command is accepted no earlier than the cycle after FIN.

## Structure
- **Package reg_seq_pkg:**
  - state enum (IDLE, LOAD, DUMP, DRAIN, FIN)
  - OP_DUMP=1'b0, OP_LOAD=1'b1
  - DEPTH/ADDR_W constants
- **Sub-module reg_seq_out_slot:**
  - one-entry valid/ready register for Dump_Data/Dump_Addr
  - inputs: load enable, data, address
  - outputs: Dump_* and a free flag
- The FSM, address counter and rem counter stay in the top module.

## Test plan
- Load Start=0, Count=32, Load_Data=i+0x100 with Load_Valid always high → Write_Reg cycles 2..33, W_Addr=0..31, Done at cycle 33; a following dump returns 0x100..0x11F in order.
- Dump Start=30, Count=4 with the file preloaded with reg[i]=i → beats (Addr, Data)=(30,30), (31,31), (0,0), (1,1); Done at cycle 6.
- Dump Count=8 with Dump_Ready toggling 1,0,0,1,… → no lost or duplicated words; Dump_Data stable while stalled; 8 beats total.
- Count=0 → Done at cycle 1, no Write_Reg, no Dump_Valid. Count=40 → exactly 32 accesses.
- Load Count=5 with Load_Valid gapped → Write_Reg count equals handshake count, each with the correct W_Addr.
- Reset low during a dump after 3 beats, held with Dump_Ready=0 → Dump_Valid=0 asynchronously, Busy=0, no Done; a new command is accepted after Reset rises.
